// File: rtl/normalizer_seq.sv
// Multi-cycle sign normalizer. A binary search shifts out redundant sign bits, one step per
// clock, and reports the normalized word and the shift count.
module normalizer_seq #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataIn,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic [CW-1:0]    shiftCount,
  output logic             isZero
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

  stateT            stateQ, stateD;
  logic [WIDTH-1:0] workQ, workD;
  logic [CW-1:0]    cntQ, cntD;
  logic [CW-1:0]    stepQ, stepD;
  logic             zeroQ, zeroD;
  logic [WIDTH-1:0] dataOutQ, dataOutD;
  logic [CW-1:0]    shiftCountQ, shiftCountD;
  logic             isZeroQ, isZeroD;

  logic [CW:0]      kVal, cntSum;
  logic [WIDTH-1:0] signDiff, topMask, stepWork;
  logic [CW-1:0]    stepCnt;
  logic             canShift;

  // signDiff[i] flags work[i] != work[i-1]; the top k+1 bits are all equal exactly when
  // signDiff is clear in the top k positions.
  always_comb begin
    kVal     = (CW+1)'(1) << stepQ;
    signDiff = workQ ^ (workQ << 1);
    topMask  = ~({WIDTH{1'b1}} >> kVal);
    cntSum   = {1'b0, cntQ} + kVal;
    canShift = ((signDiff & topMask) == '0) && (cntSum <= (CW+1)'(WIDTH - 1));
    stepWork = canShift ? (workQ << kVal) : workQ;
    stepCnt  = canShift ? cntSum[CW-1:0] : cntQ;
  end

  always_comb begin
    stateD      = stateQ;
    workD       = workQ;
    cntD        = cntQ;
    stepD       = stepQ;
    zeroD       = zeroQ;
    dataOutD    = dataOutQ;
    shiftCountD = shiftCountQ;
    isZeroD     = isZeroQ;
    unique case (stateQ)
      StIdle, StDone: begin
        if (start) begin
          stateD = StRun;
          workD  = dataIn;
          cntD   = '0;
          stepD  = CW'(CW - 1);
          zeroD  = (dataIn == '0);
        end else begin
          stateD = StIdle;
        end
      end
      StRun: begin
        workD = stepWork;
        cntD  = stepCnt;
        if (stepQ == '0) begin
          // Results are published only on the last step so outputs stay stable during RUN.
          stateD      = StDone;
          dataOutD    = stepWork;
          shiftCountD = stepCnt;
          isZeroD     = zeroQ;
        end else begin
          stepD = stepQ - CW'(1);
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ      <= StIdle;
      workQ       <= '0;
      cntQ        <= '0;
      stepQ       <= '0;
      zeroQ       <= 1'b0;
      dataOutQ    <= '0;
      shiftCountQ <= '0;
      isZeroQ     <= 1'b0;
    end else begin
      stateQ      <= stateD;
      workQ       <= workD;
      cntQ        <= cntD;
      stepQ       <= stepD;
      zeroQ       <= zeroD;
      dataOutQ    <= dataOutD;
      shiftCountQ <= shiftCountD;
      isZeroQ     <= isZeroD;
    end
  end

  assign ready      = (stateQ != StRun);
  assign done       = (stateQ == StDone);
  assign dataOut    = dataOutQ;
  assign shiftCount = shiftCountQ;
  assign isZero     = isZeroQ;

endmodule

// File: tb/tb_normalizer_seq.sv
// Scoreboard bench for normalizer_seq: expected results queued at start, compared on done.
module tb_normalizer_seq;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned CW    = 5;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    cnt;
    logic             zero;
  } expT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dataIn;
  logic             ready, done, isZero;
  logic [WIDTH-1:0] dataOut;
  logic [CW-1:0]    shiftCount;

  expT              sb[$];
  int               nChecks = 0;
  int               nPass   = 0;
  int               doneSeen = 0;
  logic [WIDTH-1:0] lastOut = '0;

  normalizer_seq #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dataIn     (dataIn),
    .ready      (ready),
    .done       (done),
    .dataOut    (dataOut),
    .shiftCount (shiftCount),
    .isZero     (isZero)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Linear reference: shift while the two top bits agree, capped at WIDTH-1.
  function automatic expT model(input logic [WIDTH-1:0] d);
    expT e;
    e.data = d;
    e.cnt  = '0;
    e.zero = (d == '0);
    while (e.cnt < CW'(WIDTH - 1) && e.data[WIDTH-1] == e.data[WIDTH-2]) begin
      e.data = e.data << 1;
      e.cnt  = e.cnt + CW'(1);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      doneSeen++;
      checkEq("doneExpected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        expT e;
        e = sb.pop_front();
        checkEq("dataOut", dataOut, e.data);
        checkEq("shiftCount", shiftCount, e.cnt);
        checkEq("isZero", isZero, e.zero);
        if (e.cnt != CW'(WIDTH - 1)) checkEq("postCond", dataOut[WIDTH-1] != dataOut[WIDTH-2], 1);
        lastOut = e.data;
      end
    end
  end

  // Called at a negedge; drives start for one edge and returns at the next negedge.
  task automatic startOp(input logic [WIDTH-1:0] d, input bit push, input expT e);
    start  = 1'b1;
    dataIn = d;
    if (push) sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    dataIn = WIDTH'($urandom);
  endtask

  // n = negedges already elapsed since the capture edge; returns at the done negedge.
  task automatic waitDone(input int n0);
    int n = n0;
    checkEq("busyReady", ready, 0);
    checkEq("heldOut", dataOut, lastOut);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkEq("latency", n, 6);
  endtask

  task automatic runOp(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] expD,
                       input logic [CW-1:0] expC, input logic expZ);
    expT e;
    e.data = expD;
    e.cnt  = expC;
    e.zero = expZ;
    startOp(d, 1'b1, e);
    waitDone(1);
    @(negedge clk);
    checkEq("donePulse", done, 0);
  endtask

  initial begin
    expT e;
    logic [WIDTH-1:0] r;
    rst    = 1'b1;
    start  = 1'b0;
    dataIn = '0;
    repeat (2) @(negedge clk);
    checkEq("rstReady", ready, 1);
    checkEq("rstDone", done, 0);
    checkEq("rstDataOut", dataOut, 0);
    checkEq("rstCount", shiftCount, 0);
    checkEq("rstIsZero", isZero, 0);
    rst = 1'b0;
    @(negedge clk);

    runOp(24'h000001, 24'h400000, 5'd22, 1'b0);
    runOp(24'hFFFFFF, 24'h800000, 5'd23, 1'b0);
    runOp(24'h000000, 24'h000000, 5'd23, 1'b1);
    runOp(24'h400000, 24'h400000, 5'd0, 1'b0);
    runOp(24'hF00000, 24'h800000, 5'd3, 1'b0);

    for (int i = 0; i < 8; i++) begin
      r = WIDTH'($urandom) >> $urandom_range(0, WIDTH - 1);
      if (i[0]) r = ~r;
      e = model(r);
      runOp(r, e.data, e.cnt, e.zero);
    end

    // Start pulsed during RUN (before E2) must be ignored.
    e.data = 24'h400000; e.cnt = 5'd22; e.zero = 1'b0;
    doneSeen = 0;
    startOp(24'h000001, 1'b1, e);
    @(negedge clk);
    start  = 1'b1;
    dataIn = 24'h123456;
    @(negedge clk);
    start  = 1'b0;
    waitDone(3);
    repeat (10) @(negedge clk);
    checkEq("ignoredStartDones", doneSeen, 1);
    checkEq("idleReady", ready, 1);

    // Back-to-back: new start accepted in the DONE cycle.
    e = model(24'h0000F0);
    startOp(24'h0000F0, 1'b1, e);
    waitDone(1);
    e.data = 24'h7F8000; e.cnt = 5'd15; e.zero = 1'b0;
    checkEq("doneReady", ready, 1);
    startOp(24'h0000FF, 1'b1, e);
    waitDone(1);
    @(negedge clk);

    // Reset between E2 and E3 discards the operation and clears outputs.
    doneSeen = 0;
    startOp(24'h000010, 1'b0, e);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkEq("midRstReady", ready, 1);
    checkEq("midRstDone", done, 0);
    checkEq("midRstDataOut", dataOut, 0);
    checkEq("midRstCount", shiftCount, 0);
    checkEq("midRstIsZero", isZero, 0);
    lastOut = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkEq("midRstNoDone", doneSeen, 0);

    runOp(24'h0000FF, 24'h7F8000, 5'd15, 1'b0);
    checkEq("sbDrained", sb.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
